acc_rr_sched: RTL and testbench

- Round-robin scheduler that shares one windowed sum accumulator between NREQ requesters. Each accumulation sums DEPTH samples.
- A granted requester streams DEPTH samples. The block accumulates them and returns one tagged sum, then re-arbitrates.
- Sits between multiple sample producers and the downstream consumer of the windowed sum.

---
 rtl/acc_rr_sched.sv | 126 ++++++++++++
 tb/tb_acc_rr_sched.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_rr_sched.sv
// Round-robin scheduler sharing one windowed-sum accumulator among NREQ requesters.
// A granted requester streams DEPTH samples; the block returns one tagged sum, then re-arbitrates.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests starting at ptr
// BURST | grant held; accumulate samples from the selected requester
// DONE  | result pulse visible, pointer advances past the served requester
module acc_rr_sched #(
    parameter int NREQ  = 4,
    parameter int N     = 8,
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(NREQ),
    localparam int OW   = N + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] din,
    input  logic [NREQ-1:0]   din_vld,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [OW-1:0]     dout,
    output logic [IW-1:0]     dout_id,
    output logic              dout_vld,
    output logic              abort
);

    localparam int CW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [OW-1:0] acc;

    logic [IW-1:0] pick;
    logic          found;
    logic [IW-1:0] sel_inc;
    logic [N-1:0]  sel_din;
    logic          sel_vld;
    logic          sel_req;
    logic [OW-1:0] sample_ext;
    logic [OW-1:0] acc_next;
    logic          last_sample;

    // First pending request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                pick  = IW'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    assign sel_inc     = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
    assign sel_din     = din[int'(sel) * N +: N];
    assign sel_vld     = din_vld[sel];
    assign sel_req     = req[sel];
    assign sample_ext  = {{(OW - N){1'b0}}, sel_din};
    assign acc_next    = (cnt == '0) ? sample_ext : acc + sample_ext;
    assign last_sample = (cnt == CW'(DEPTH - 1));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            sel      <= '0;
            cnt      <= '0;
            acc      <= '0;
            gnt      <= '0;
            dout     <= '0;
            dout_id  <= '0;
            dout_vld <= 1'b0;
            abort    <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            abort    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        gnt   <= {{(NREQ - 1){1'b0}}, 1'b1} << pick;
                        cnt   <= '0;
                        state <= S_BURST;
                    end
                end
                S_BURST: begin
                    // A dropped request wins over a sample presented in the same cycle.
                    if (!sel_req) begin
                        gnt   <= '0;
                        abort <= 1'b1;
                        ptr   <= sel_inc;
                        state <= S_IDLE;
                    end else if (sel_vld) begin
                        acc <= acc_next;
                        cnt <= cnt + CW'(1);
                        if (last_sample) begin
                            gnt      <= '0;
                            dout     <= acc_next;
                            dout_id  <= sel;
                            dout_vld <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    ptr   <= sel_inc;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_rr_sched.sv
// Self-checking bench for acc_rr_sched: producer models per requester, event logs,
// and a round-robin/sum reference model evaluated at the burst level.
module tb_acc_rr_sched;
    localparam int NREQ  = 4;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 2;
    localparam int OW    = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] din;
    logic [NREQ-1:0]   din_vld;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [OW-1:0]     dout;
    logic [IW-1:0]     dout_id;
    logic              dout_vld;
    logic              abort;

    always #5 clk = ~clk;

    acc_rr_sched #(.NREQ(NREQ), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .din_vld(din_vld),
        .gnt(gnt), .busy(busy), .dout(dout), .dout_id(dout_id),
        .dout_vld(dout_vld), .abort(abort)
    );

    int checks = 0;
    int errors = 0;

    // Producer models
    logic [N-1:0]    p_data [NREQ][DEPTH];
    int              p_idx [NREQ];
    int              p_mode [NREQ];       // 0 always valid, 1 pattern 1,0,0, 2 random, 3 hold off
    int              p_phase [NREQ];
    int              p_drop_after [NREQ];
    int              last_acc_cyc [NREQ];
    bit              p_noise [NREQ];
    bit              p_autodrop [NREQ];
    logic [NREQ-1:0] p_req;
    logic [NREQ-1:0] gnt_prev;
    int              cyc;
    int              inv_err;

    // Observed events
    int ev_gnt_id[$], ev_gnt_cyc[$];
    int ev_out_id[$], ev_out_cyc[$], ev_out_val[$];
    int ev_abort_cyc[$], ev_abort_dout[$];

    // Reference model state
    int m_ptr;
    int m_last_sum;

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int burst_sum(input int i);
        int s = 0;
        for (int j = 0; j < DEPTH; j++) s += int'(p_data[i][j]);
        return s;
    endfunction

    task automatic clear_events();
        ev_gnt_id.delete(); ev_gnt_cyc.delete();
        ev_out_id.delete(); ev_out_cyc.delete(); ev_out_val.delete();
        ev_abort_cyc.delete(); ev_abort_dout.delete();
    endtask

    task automatic clear_producers();
        p_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_idx[i] = 0; p_mode[i] = 0; p_phase[i] = 0; p_drop_after[i] = -1;
            p_noise[i] = 1'b0; p_autodrop[i] = 1'b0; last_acc_cyc[i] = -1;
            for (int j = 0; j < DEPTH; j++) p_data[i][j] = '0;
        end
    endtask

    // One cycle: observe outputs at negedge, then drive the next inputs.
    task automatic step();
        logic [NREQ*N-1:0] d_v;
        logic [NREQ-1:0]   v_v;
        bit                v;
        @(negedge clk);
        cyc++;
        if (dout_vld && abort) inv_err++;
        if (busy !== ((gnt != '0) || dout_vld)) inv_err++;
        if (!$onehot0(gnt)) inv_err++;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i] && !gnt_prev[i]) begin
                ev_gnt_id.push_back(i);
                ev_gnt_cyc.push_back(cyc);
            end
        if (dout_vld) begin
            ev_out_id.push_back(int'(dout_id));
            ev_out_val.push_back(int'(dout));
            ev_out_cyc.push_back(cyc);
            if (p_autodrop[dout_id]) p_req[dout_id] = 1'b0;
        end
        if (abort) begin
            ev_abort_cyc.push_back(cyc);
            ev_abort_dout.push_back(int'(dout));
        end
        d_v = '0;
        v_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && !gnt_prev[i]) begin
                p_idx[i] = 0;
                p_phase[i] = 0;
            end else if (gnt[i]) begin
                if (p_idx[i] < DEPTH) begin
                    if (p_drop_after[i] >= 0 && p_idx[i] == p_drop_after[i]) p_req[i] = 1'b0;
                    case (p_mode[i])
                        0:       v = 1'b1;
                        1:       v = (p_phase[i] % 3 == 0);
                        2:       v = 1'($urandom_range(0, 1));
                        default: v = 1'b0;
                    endcase
                    p_phase[i]++;
                    if (v) begin
                        d_v[i*N +: N] = p_data[i][p_idx[i]];
                        v_v[i] = 1'b1;
                        if (p_req[i]) begin
                            p_idx[i]++;
                            last_acc_cyc[i] = cyc;
                        end
                    end
                end
            end else if (p_noise[i]) begin
                d_v[i*N +: N] = '1;
                v_v[i] = 1'($urandom_range(0, 1));
            end
        end
        gnt_prev = gnt;
        req      = p_req;
        din      = d_v;
        din_vld  = v_v;
    endtask

    task automatic run_until_outs(input int n, input int budget);
        for (int t = 0; t < budget && ev_out_id.size() < n; t++) step();
    endtask

    task automatic test_reset();
        clear_producers();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, busy, dout_vld, abort} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b dout_vld=%b abort=%b, want all 0", gnt, busy, dout_vld, abort);
        end
        checks++;
        if ({dout, dout_id} !== '0) begin
            errors++;
            $display("FAIL reset_data: dout=%0d dout_id=%0d, want 0 0", dout, dout_id);
        end
        rst = 1'b0;
        m_ptr = 0;
        m_last_sum = 0;
        step();
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b gnt=%b, want 0 0000", busy, gnt);
        end
    endtask

    task automatic test_all_four();
        int ptr, id, inv0;
        clear_producers();
        clear_events();
        inv0 = inv_err;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < DEPTH; j++) p_data[i][j] = N'(i + 1);
        p_req = '1;
        run_until_outs(5, 120);
        p_req = '0;
        step();
        step();
        checks++;
        if (ev_out_id.size() != 5 || ev_gnt_id.size() != 5) begin
            errors++;
            $display("FAIL rr_counts: outs=%0d grants=%0d, want 5 5", ev_out_id.size(), ev_gnt_id.size());
        end
        ptr = m_ptr;
        for (int e = 0; e < 5 && e < ev_out_id.size() && e < ev_gnt_id.size(); e++) begin
            id = rr_pick(ptr, '1);
            checks++;
            if (ev_gnt_id[e] != id || ev_out_id[e] != id) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%0d out_id=%0d, want %0d", e, ev_gnt_id[e], ev_out_id[e], id);
            end
            checks++;
            if (ev_out_val[e] != DEPTH * (id + 1)) begin
                errors++;
                $display("FAIL rr_sum[%0d]: got %0d want %0d", e, ev_out_val[e], DEPTH * (id + 1));
            end
            if (e > 0) begin
                checks++;
                if (ev_gnt_cyc[e] - ev_gnt_cyc[e-1] != DEPTH + 3) begin
                    errors++;
                    $display("FAIL rr_period[%0d]: got %0d want %0d", e, ev_gnt_cyc[e] - ev_gnt_cyc[e-1], DEPTH + 3);
                end
            end
            ptr = (id + 1) % NREQ;
            m_last_sum = DEPTH * (id + 1);
        end
        m_ptr = ptr;
        checks++;
        if (inv_err != inv0 || ev_abort_cyc.size() != 0) begin
            errors++;
            $display("FAIL rr_invariants: violations=%0d aborts=%0d, want 0 0", inv_err - inv0, ev_abort_cyc.size());
        end
    endtask

    task automatic test_single();
        int req_cyc;
        clear_producers();
        clear_events();
        for (int j = 0; j < DEPTH; j++) p_data[2][j] = N'(j + 1);
        p_req[2] = 1'b1;
        p_autodrop[2] = 1'b1;
        step();
        req_cyc = cyc;
        run_until_outs(1, 60);
        checks++;
        if (ev_gnt_id.size() < 1 || ev_gnt_id[0] != rr_pick(m_ptr, 4'b0100) || ev_gnt_cyc[0] != req_cyc + 1) begin
            errors++;
            $display("FAIL single_grant: grants=%0d id=%0d cyc=%0d, want id 2 at cyc %0d",
                     ev_gnt_id.size(), ev_gnt_id.size() > 0 ? ev_gnt_id[0] : -1,
                     ev_gnt_cyc.size() > 0 ? ev_gnt_cyc[0] : -1, req_cyc + 1);
        end
        checks++;
        if (ev_out_id.size() != 1 || ev_out_val[0] != burst_sum(2) || ev_out_id[0] != 2) begin
            errors++;
            $display("FAIL single_sum: outs=%0d dout=%0d id=%0d, want 36 id 2", ev_out_id.size(),
                     ev_out_val.size() > 0 ? ev_out_val[0] : -1, ev_out_id.size() > 0 ? ev_out_id[0] : -1);
        end
        checks++;
        if (ev_out_cyc.size() < 1 || ev_out_cyc[0] != last_acc_cyc[2] + 1) begin
            errors++;
            $display("FAIL single_latency: dout_vld cyc=%0d, want %0d",
                     ev_out_cyc.size() > 0 ? ev_out_cyc[0] : -1, last_acc_cyc[2] + 1);
        end
        m_ptr = 3;
        m_last_sum = burst_sum(2);
        step(); step(); step();
        checks++;
        if (dout !== OW'(m_last_sum) || dout_id !== 2'd2 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: dout=%0d id=%0d vld=%b, want %0d 2 0", dout, dout_id, dout_vld, m_last_sum);
        end
    endtask

    task automatic test_stall();
        int exp_cyc;
        clear_producers();
        clear_events();
        for (int j = 0; j < DEPTH; j++) p_data[1][j] = '1;
        p_mode[1] = 1;
        p_req[1] = 1'b1;
        p_autodrop[1] = 1'b1;
        run_until_outs(1, 100);
        step();
        checks++;
        if (ev_out_id.size() != 1 || ev_out_val[0] != DEPTH * 255 || ev_out_id[0] != 1) begin
            errors++;
            $display("FAIL stall_sum: outs=%0d dout=%0d id=%0d, want %0d id 1", ev_out_id.size(),
                     ev_out_val.size() > 0 ? ev_out_val[0] : -1, ev_out_id.size() > 0 ? ev_out_id[0] : -1, DEPTH * 255);
        end
        exp_cyc = (ev_gnt_cyc.size() > 0 ? ev_gnt_cyc[0] : 0) + 1 + 3 * (DEPTH - 1) + 1;
        checks++;
        if (ev_out_cyc.size() < 1 || ev_out_cyc[0] != exp_cyc) begin
            errors++;
            $display("FAIL stall_timing: dout_vld cyc=%0d, want %0d", ev_out_cyc.size() > 0 ? ev_out_cyc[0] : -1, exp_cyc);
        end
        m_ptr = 2;
        m_last_sum = DEPTH * 255;
    endtask

    task automatic test_abort();
        int first;
        clear_producers();
        clear_events();
        for (int j = 0; j < DEPTH; j++) begin
            p_data[3][j] = N'($urandom);
            p_data[0][j] = N'($urandom);
        end
        p_req = 4'b1001;
        p_drop_after[3] = 4;
        p_autodrop[0] = 1'b1;
        first = rr_pick(m_ptr, 4'b1001);
        run_until_outs(1, 80);
        step();
        checks++;
        if (ev_gnt_id.size() != 2 || ev_gnt_id[0] != first || ev_gnt_id[1] != 0) begin
            errors++;
            $display("FAIL abort_grants: n=%0d first=%0d, want 2 grants %0d then 0", ev_gnt_id.size(),
                     ev_gnt_id.size() > 0 ? ev_gnt_id[0] : -1, first);
        end
        checks++;
        if (ev_abort_cyc.size() != 1 || ev_abort_cyc[0] != last_acc_cyc[3] + 2) begin
            errors++;
            $display("FAIL abort_pulse: n=%0d cyc=%0d, want 1 at %0d", ev_abort_cyc.size(),
                     ev_abort_cyc.size() > 0 ? ev_abort_cyc[0] : -1, last_acc_cyc[3] + 2);
        end
        checks++;
        if (ev_abort_dout.size() < 1 || ev_abort_dout[0] != m_last_sum) begin
            errors++;
            $display("FAIL abort_dout_hold: dout=%0d, want %0d", ev_abort_dout.size() > 0 ? ev_abort_dout[0] : -1, m_last_sum);
        end
        checks++;
        if (ev_abort_cyc.size() < 1 || ev_gnt_cyc.size() < 2 || ev_gnt_cyc[1] != ev_abort_cyc[0] + 1) begin
            errors++;
            $display("FAIL abort_regrant: gnt cyc=%0d, want abort cyc + 1", ev_gnt_cyc.size() > 1 ? ev_gnt_cyc[1] : -1);
        end
        checks++;
        if (ev_out_id.size() != 1 || ev_out_id[0] != 0 || ev_out_val[0] != burst_sum(0)) begin
            errors++;
            $display("FAIL abort_next_sum: outs=%0d id=%0d dout=%0d, want 1 id 0 %0d", ev_out_id.size(),
                     ev_out_id.size() > 0 ? ev_out_id[0] : -1, ev_out_val.size() > 0 ? ev_out_val[0] : -1, burst_sum(0));
        end
        m_ptr = 1;
        m_last_sum = burst_sum(0);
    endtask

    task automatic test_noise();
        clear_producers();
        clear_events();
        p_noise[0] = 1'b1;
        p_noise[1] = 1'b1;
        p_noise[3] = 1'b1;
        p_req[2] = 1'b1;
        p_autodrop[2] = 1'b1;
        run_until_outs(1, 60);
        step();
        checks++;
        if (ev_out_id.size() != 1 || ev_out_val[0] != 0 || ev_out_id[0] != rr_pick(m_ptr, 4'b0100)) begin
            errors++;
            $display("FAIL noise_isolation: outs=%0d dout=%0d id=%0d, want 0 id 2", ev_out_id.size(),
                     ev_out_val.size() > 0 ? ev_out_val[0] : -1, ev_out_id.size() > 0 ? ev_out_id[0] : -1);
        end
        m_ptr = 3;
        m_last_sum = 0;
    endtask

    task automatic test_reset_mid();
        int id, ptr;
        clear_producers();
        clear_events();
        for (int j = 0; j < DEPTH; j++) p_data[3][j] = N'($urandom_range(1, 255));
        p_req[3] = 1'b1;
        for (int t = 0; t < 40 && p_idx[3] < 5; t++) step();
        p_mode[3] = 3;
        step();
        rst = 1'b1;
        p_req = '0;
        step();
        rst = 1'b0;
        checks++;
        if ({gnt, busy, dout_vld, abort} !== '0 || {dout, dout_id} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: gnt=%b busy=%b dout=%0d id=%0d vld=%b abort=%b, want all 0",
                     gnt, busy, dout, dout_id, dout_vld, abort);
        end
        step(); step();
        checks++;
        if (ev_out_id.size() != 0 || ev_abort_cyc.size() != 0) begin
            errors++;
            $display("FAIL midreset_dropped: outs=%0d aborts=%0d, want 0 0", ev_out_id.size(), ev_abort_cyc.size());
        end
        m_ptr = 0;
        clear_producers();
        clear_events();
        for (int j = 0; j < DEPTH; j++) begin
            p_data[1][j] = N'($urandom);
            p_data[3][j] = N'($urandom);
        end
        p_req = 4'b1010;
        p_autodrop[1] = 1'b1;
        p_autodrop[3] = 1'b1;
        run_until_outs(2, 80);
        step();
        ptr = m_ptr;
        for (int e = 0; e < 2; e++) begin
            id = rr_pick(ptr, e == 0 ? 4'b1010 : 4'b1010 & ~(4'b0001 << rr_pick(m_ptr, 4'b1010)));
            checks++;
            if (ev_out_id.size() <= e || ev_out_id[e] != id || ev_out_val[e] != burst_sum(id)) begin
                errors++;
                $display("FAIL midreset_fresh[%0d]: id=%0d dout=%0d, want id %0d sum %0d", e,
                         ev_out_id.size() > e ? ev_out_id[e] : -1, ev_out_val.size() > e ? ev_out_val[e] : -1, id, burst_sum(id));
            end
            ptr = (id + 1) % NREQ;
            m_last_sum = burst_sum(id);
        end
        m_ptr = ptr;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask, pending;
        int id, n, inv0;
        inv0 = inv_err;
        for (int r = 0; r < 6; r++) begin
            clear_producers();
            clear_events();
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                for (int j = 0; j < DEPTH; j++) p_data[i][j] = N'($urandom);
                p_mode[i] = ($urandom_range(0, 1) == 1) ? 2 : 0;
                p_noise[i] = 1'($urandom_range(0, 1));
                p_autodrop[i] = 1'b1;
            end
            p_req = mask;
            n = $countones(mask);
            run_until_outs(n, 400);
            step();
            checks++;
            if (ev_out_id.size() != n || ev_abort_cyc.size() != 0) begin
                errors++;
                $display("FAIL rand_count[%0d]: outs=%0d aborts=%0d, want %0d 0", r, ev_out_id.size(), ev_abort_cyc.size(), n);
            end
            pending = mask;
            for (int e = 0; e < n && e < ev_out_id.size(); e++) begin
                id = rr_pick(m_ptr, pending);
                checks++;
                if (ev_out_id[e] != id || ev_out_val[e] != burst_sum(id)) begin
                    errors++;
                    $display("FAIL rand_burst[%0d.%0d]: id=%0d dout=%0d, want id %0d sum %0d", r, e,
                             ev_out_id[e], ev_out_val[e], id, burst_sum(id));
                end
                pending[id] = 1'b0;
                m_ptr = (id + 1) % NREQ;
            end
            step();
        end
        checks++;
        if (inv_err != inv0) begin
            errors++;
            $display("FAIL rand_invariants: violations=%0d, want 0", inv_err - inv0);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        din_vld = '0;
        gnt_prev = '0;
        cyc = 0;
        inv_err = 0;
        clear_producers();
        test_reset();
        test_all_four();
        test_single();
        test_stall();
        test_abort();
        test_noise();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
